pi_integrator_mc: RTL and testbench
===================================

# pi_integrator_mc

Multi-channel, time-multiplexed fixed-point PI discrete integrator with output limiting and anti-windup. It computes y[n] = A·x[n] + B·x[n-1] + y[n-1], clamped to [LOWER, UPPER], with A = Δt/2·Ki + Kp and B = Δt/2·Ki − Kp. Per-channel state is held in internal register arrays indexed by channel number, so no external FIFOs or read/write enable sequencing are needed. It sits in the wind-turbine control path and serves N_CH turbines from one arithmetic pipeline.

## Interface
- W, 32: signed data width, two's-complement fixed point.
- FRAC, 16: fractional bits of x, y, A, B, INIT, UPPER, LOWER.
- N_CH, 8: channel count (≥1); CHW = max(1, clog2(N_CH)).
- A, 32'h0001_8000: coefficient on x[n].
- B, 32'hFFFF_8000: coefficient on x[n-1].
- UPPER, 32'h000A_0000: upper output limit. Must satisfy LOWER ≤ UPPER.
- LOWER, 32'hFFF6_0000: lower output limit.
- INIT, 0: y state loaded by a clear.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe. One sample may be accepted every cycle; there is no backpressure.
- in_ch  in  CHW  channel index of the sample.
- x  in  W  input sample.
- hold  in  1  with in_valid: freeze the y state of in_ch.
- clr  in  1  with in_valid: clear the channel state.
- out_valid  out  1  result strobe.
- out_ch  out  CHW  channel of the result.
- y  out  W  limited result.
- sat  out  1  the result was clamped.
- ch_err  out  1  one-cycle pulse: in_ch ≥ N_CH, sample dropped.

## Operation
- S1 (input edge):
  - Capture x, in_ch, hold, clr.
  - Capture x_prev = x_state[in_ch].
  - Write x_state[in_ch] ← x, or ← 0 if clr.
- S2 (next edge):
  - pA = A·x and pB = B·x_prev, each a full 2W signed product.
  - Register pA and pB.
- S3 (next edge):
  - s = (pA >>> FRAC) + (pB >>> FRAC) + y_state[ch], computed at W+2 bits. The shift is arithmetic and truncates toward −∞.
  - y = clamp(s, LOWER, UPPER); sat = (s > UPPER) or (s < LOWER).
  - Write y_state[ch] ← y. Because the stored state is the clamped value, this is the anti-windup.
- hold = 1: y = y_state[ch] unchanged, sat = 0, no y_state write. x_state still updates.
- clr = 1 (has priority over hold): x_state ← 0, y_state ← INIT, y = INIT, sat = 0.
- Invalid channel (in_ch ≥ N_CH): no state change, no out_valid, ch_err pulses on the cycle after the input cycle.
- rst:
  - All x_state and y_state entries ← 0 (not INIT).
  - Pipeline valids ← 0 and in-flight samples are discarded.
  - Outputs reset to out_valid = 0, out_ch = 0, y = 0, sat = 0, ch_err = 0.
  - in_valid during rst is ignored.

## Timing
- Latency: a sample presented in cycle n appears with out_valid in cycle n+3. Throughput is 1 sample per cycle.
- Back-to-back samples on the same channel are hazard-free:
  - x_state is written at the S1 edge.
  - y_state is written at the S3 edge and read combinationally during the next sample's S3 cycle.
  - No forwarding is required.
- out_valid is high for exactly one cycle per accepted sample. y, out_ch and sat hold their values between strobes.
- The first rising edge after rst deasserts may sample in_valid.

## Structure
- Package pi_pkg: the clamp function, the CHW width helper, and Q-format constants for tests.
- Sub-module pi_limit: combinational clamp over W+2 bits producing y[W-1:0] and sat. It replaces the per-design limit block.
- State arrays are flop-based at N_CH × W each; no RAM macro is used.

## Test plan
Defaults throughout: A = 1.5, B = −0.5, limits ±10.0, Q16.16.
- Single-channel step: ch0, x = 0x10000 for three consecutive cycles → y = 0x18000, 0x28000, 0x38000 in cycles 3, 4, 5; sat = 0.
- Interleave:
  - Inputs ch0 x = 1.0, ch1 x = 2.0, ch0 x = 1.0, ch1 x = 2.0 back-to-back.
  - Expect y = 1.5, 3.0, 2.5, 5.0; out_ch = 0, 1, 0, 1.
- Saturation and anti-windup:
  - ch2, x = 8.0 twice → y = 0xA0000 with sat = 1 both times.
  - Then x = 0 → 10 − 4 = 6.0, i.e. y = 0x60000 with sat = 0.
- Hold and clear:
  - After ch0 reaches y = 2.5, send hold with x = 1.0 → y = 2.5.
  - Then send clr → y = INIT = 0.
  - Then x = 1.0 → y = 1.5.
- Reset mid-stream:
  - Assert rst while 3 samples are in flight → no out_valid for them; y = 0 and out_valid = 0 on the cycle after the rst edge.
  - Then ch0 x = 1.0 → y = 1.5.
- Invalid channel: N_CH = 6, in_ch = 7 → ch_err pulses once, no out_valid, and a subsequent ch0 result is unchanged.

Source files
------------

// File: rtl/pi_pkg.sv
// Shared helpers for the multi-channel PI integrator: channel-index width,
// the generic clamp, and Q16.16 constants.
package pi_pkg;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] s,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    localparam logic signed [31:0] Q_ONE   = 32'sh0001_0000;
    localparam logic signed [31:0] Q_TWO   = 32'sh0002_0000;
    localparam logic signed [31:0] Q_EIGHT = 32'sh0008_0000;

endpackage

// File: rtl/pi_limit.sv
// Combinational output limiter: clamps the W+2-bit sum into [LOWER, UPPER]
// and flags when clamping took place.
module pi_limit
    import pi_pkg::*;
#(
    parameter int                  W     = 32,
    parameter logic signed [W-1:0] UPPER = 32'sh000A_0000,
    parameter logic signed [W-1:0] LOWER = 32'shFFF6_0000
) (
    input  logic signed [W+1:0] s,
    output logic signed [W-1:0] y,
    output logic                sat
);

    logic signed [63:0] s_ext;
    logic signed [63:0] hi_ext;
    logic signed [63:0] lo_ext;
    logic signed [63:0] c;

    always_comb begin
        s_ext  = 64'(s);
        hi_ext = 64'(UPPER);
        lo_ext = 64'(LOWER);
        c      = clamp(s_ext, lo_ext, hi_ext);
        y      = W'(c);
        sat    = (s_ext > hi_ext) || (s_ext < lo_ext);
    end

endmodule

// File: rtl/pi_integrator_mc.sv
// Time-multiplexed PI integrator y[n] = A*x[n] + B*x[n-1] + y[n-1] with
// limiting and anti-windup; per-channel x/y state lives in flop arrays.
module pi_integrator_mc
    import pi_pkg::*;
#(
    parameter int                  W     = 32,
    parameter int                  FRAC  = 16,
    parameter int                  N_CH  = 8,
    parameter logic signed [W-1:0] A     = 32'sh0001_8000,
    parameter logic signed [W-1:0] B     = 32'shFFFF_8000,
    parameter logic signed [W-1:0] UPPER = 32'sh000A_0000,
    parameter logic signed [W-1:0] LOWER = 32'shFFF6_0000,
    parameter logic signed [W-1:0] INIT  = '0,
    localparam int                 CHW   = ch_width(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [CHW-1:0]      in_ch,
    input  logic signed [W-1:0] x,
    input  logic                hold,
    input  logic                clr,
    output logic                out_valid,
    output logic [CHW-1:0]      out_ch,
    output logic signed [W-1:0] y,
    output logic                sat,
    output logic                ch_err
);

    // Full-precision product, arithmetic shift (floor), kept at W+2 bits.
    function automatic logic signed [W+1:0] scale_prod(input logic signed [W-1:0] c,
                                                       input logic signed [W-1:0] d);
        return (W+2)'(((2*W)'(c) * (2*W)'(d)) >>> FRAC);
    endfunction

    logic signed [W-1:0] x_state [N_CH];
    logic signed [W-1:0] y_state [N_CH];

    logic ch_ok;
    assign ch_ok = 32'(in_ch) < N_CH;

    // S1: capture the sample and x[n-1], update x_state
    logic                vld_p0;
    logic                hold_p0;
    logic                clr_p0;
    logic [CHW-1:0]      ch_p0;
    logic signed [W-1:0] x_p0;
    logic signed [W-1:0] xprev_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            ch_err <= 1'b0;
            for (int i = 0; i < N_CH; i++) x_state[i] <= '0;
        end else begin
            vld_p0 <= in_valid && ch_ok;
            ch_err <= in_valid && !ch_ok;
            if (in_valid && ch_ok) x_state[in_ch] <= clr ? '0 : x;
        end
    end

    always_ff @(posedge clk) begin
        x_p0     <= x;
        xprev_p0 <= x_state[in_ch];
        ch_p0    <= in_ch;
        hold_p0  <= hold;
        clr_p0   <= clr;
    end

    // S2: coefficient products, pre-scaled back to the data Q format
    logic                vld_p1;
    logic                hold_p1;
    logic                clr_p1;
    logic [CHW-1:0]      ch_p1;
    logic signed [W+1:0] pa_p1;
    logic signed [W+1:0] pb_p1;

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        pa_p1   <= scale_prod(A, x_p0);
        pb_p1   <= scale_prod(B, xprev_p0);
        ch_p1   <= ch_p0;
        hold_p1 <= hold_p0;
        clr_p1  <= clr_p0;
    end

    // S3: accumulate, limit, store clamped state (anti-windup)
    logic signed [W+1:0] sum;
    logic signed [W-1:0] y_lim;
    logic                sat_lim;

    assign sum = pa_p1 + pb_p1 + (W+2)'(y_state[ch_p1]);

    pi_limit #(
        .W    (W),
        .UPPER(UPPER),
        .LOWER(LOWER)
    ) u_limit (
        .s  (sum),
        .y  (y_lim),
        .sat(sat_lim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            y         <= '0;
            sat       <= 1'b0;
            for (int i = 0; i < N_CH; i++) y_state[i] <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_ch <= ch_p1;
                if (clr_p1) begin
                    y               <= INIT;
                    sat             <= 1'b0;
                    y_state[ch_p1]  <= INIT;
                end else if (hold_p1) begin
                    y   <= y_state[ch_p1];
                    sat <= 1'b0;
                end else begin
                    y               <= y_lim;
                    sat             <= sat_lim;
                    y_state[ch_p1]  <= y_lim;
                end
            end
        end
    end

endmodule

// File: tb/tb_pi_integrator_mc.sv
// Directed scoreboard bench for pi_integrator_mc (N_CH = 6, default Q16.16 coefficients).
module tb_pi_integrator_mc;
    import pi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_ch;
    logic [31:0] x;
    logic        hold;
    logic        clr;
    logic        out_valid;
    logic [2:0]  out_ch;
    logic [31:0] y;
    logic        sat;
    logic        ch_err;

    pi_integrator_mc #(.N_CH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .x        (x),
        .hold     (hold),
        .clr      (clr),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .y        (y),
        .sat      (sat),
        .ch_err   (ch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] y;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cherr  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ch_err === 1'b1) n_cherr++;
        if (out_valid !== 1'b0) begin
            if (sbq.size() == 0) begin
                check("out_unexpected", 64'(out_valid), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("out_ch", 64'(out_ch), 64'(mon_e.ch));
                check("y", 64'(y), 64'(mon_e.y));
                check("sat", 64'(sat), 64'(mon_e.sat));
                check("latency", 64'(cyc - mon_e.cyc), 64'd3);
            end
        end
    end

    task automatic drive(input logic [2:0] ch, input logic [31:0] xv, input logic h,
                         input logic c, input logic push, input logic [31:0] ey,
                         input logic es);
        in_valid = 1'b1;
        in_ch    = ch;
        x        = xv;
        hold     = h;
        clr      = c;
        if (push) sbq.push_back('{ch, ey, es, cyc});
    endtask

    task automatic send(input logic [2:0] ch, input logic [31:0] xv, input logic h,
                        input logic c, input logic push, input logic [31:0] ey,
                        input logic es);
        @(posedge clk);
        #1;
        drive(ch, xv, h, c, push, ey, es);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hold     = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ch    = '0;
        x        = '0;
        hold     = 1'b0;
        clr      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        check("rst_ch_err", 64'(ch_err), 64'd0);

        // single-channel step, first sample on the edge right after reset release
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0001_8000, 1'b0);
        send(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0002_8000, 1'b0);
        send(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0003_8000, 1'b0);

        // clear ch0/ch1 (x ignored on clear), then interleave
        send(3'd0, 32'h0001_2345, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        send(3'd1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        send(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0001_8000, 1'b0);
        send(3'd1, Q_TWO, 1'b0, 1'b0, 1'b1, 32'h0003_0000, 1'b0);
        send(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0002_8000, 1'b0);
        send(3'd1, Q_TWO, 1'b0, 1'b0, 1'b1, 32'h0005_0000, 1'b0);

        // saturation and anti-windup on both limits
        send(3'd2, Q_EIGHT, 1'b0, 1'b0, 1'b1, 32'h000A_0000, 1'b1);
        send(3'd2, Q_EIGHT, 1'b0, 1'b0, 1'b1, 32'h000A_0000, 1'b1);
        send(3'd2, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0006_0000, 1'b0);
        send(3'd3, -Q_EIGHT, 1'b0, 1'b0, 1'b1, 32'hFFF6_0000, 1'b1);

        // hold, clear, resume on ch0 (y state 2.5)
        send(3'd0, Q_ONE, 1'b1, 1'b0, 1'b1, 32'h0002_8000, 1'b0);
        send(3'd0, 32'h0001_2345, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        send(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0001_8000, 1'b0);
        idle();
        drain();

        // reset with three samples in flight
        send(3'd1, Q_ONE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        send(3'd2, Q_ONE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        drive(3'd0, Q_ONE, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_y", 64'(y), 64'd0);
        check("midrst_sat", 64'(sat), 64'd0);
        send(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0001_8000, 1'b0);

        // invalid channels: dropped, one-cycle ch_err each, ch0 unaffected
        send(3'd7, Q_EIGHT, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        @(negedge clk);
        check("ch_err_pulse", 64'(ch_err), 64'd1);
        @(negedge clk);
        check("ch_err_clear", 64'(ch_err), 64'd0);
        send(3'd6, Q_EIGHT, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        send(3'd0, Q_ONE, 1'b0, 1'b0, 1'b1, 32'h0002_8000, 1'b0);
        idle();
        drain();
        check("ch_err_count", 64'(n_cherr), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
